// File: rtl/axil_regfile_slave.sv
// AXI4-Lite slave exposing a bank of C_NUM_REGS registers of C_DATA_WIDTH bits.
//
// Each register is either writable (stored here, mirrored on reg_out) or
// read-only (C_RO_MASK bit set: reads return the matching status_in slice,
// writes are refused with SLVERR). Indices past C_NUM_REGS answer SLVERR.
// The write side takes AW and W in any order and commits on the edge where
// the second one arrives. The read side returns data one cycle after AR.
// Each channel allows at most one outstanding transaction.
//
// Ports
//   ACLK, ARESET            clock, synchronous active-high reset
//   S_AW* / S_W* / S_B*     AXI4-Lite write address, write data, write response
//   S_AR* / S_R*            AXI4-Lite read address, read data
//   reg_out                 current register contents (read-only slots drive 0)
//   status_in               sources for the read-only registers
//   wr_pulse                one-cycle strobe per register on each accepted commit
module axil_regfile_slave #(
  parameter int                    C_DATA_WIDTH = 32,
  parameter int                    C_NUM_REGS   = 16,
  parameter int                    C_ADDR_WIDTH = 8,
  parameter logic [C_NUM_REGS-1:0] C_RO_MASK    = '0
) (
  input  logic                               ACLK,
  input  logic                               ARESET,
  input  logic [C_ADDR_WIDTH-1:0]            S_AWADDR,
  input  logic [2:0]                         S_AWPROT,
  input  logic                               S_AWVALID,
  output logic                               S_AWREADY,
  input  logic [C_DATA_WIDTH-1:0]            S_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0]          S_WSTRB,
  input  logic                               S_WVALID,
  output logic                               S_WREADY,
  output logic [1:0]                         S_BRESP,
  output logic                               S_BVALID,
  input  logic                               S_BREADY,
  input  logic [C_ADDR_WIDTH-1:0]            S_ARADDR,
  input  logic [2:0]                         S_ARPROT,
  input  logic                               S_ARVALID,
  output logic                               S_ARREADY,
  output logic [C_DATA_WIDTH-1:0]            S_RDATA,
  output logic [1:0]                         S_RRESP,
  output logic                               S_RVALID,
  input  logic                               S_RREADY,
  output logic [C_NUM_REGS*C_DATA_WIDTH-1:0] reg_out,
  input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0] status_in,
  output logic [C_NUM_REGS-1:0]              wr_pulse
);

  localparam int STRB_W = C_DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = C_ADDR_WIDTH - OFF_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE    = 2'd0;
  localparam logic [1:0] W_HAVE_AW = 2'd1;
  localparam logic [1:0] W_HAVE_W  = 2'd2;
  localparam logic [1:0] W_RESP    = 2'd3;

  localparam logic R_IDLE = 1'b0;
  localparam logic R_DATA = 1'b1;

  logic [1:0]              w_state;
  logic                    r_state;
  logic [C_ADDR_WIDTH-1:0] aw_addr_q;
  logic [C_DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]       w_strb_q;
  logic [C_DATA_WIDTH-1:0] regs [C_NUM_REGS];

  logic                    aw_hs, w_hs, ar_hs, have_aw, have_w, commit;
  logic [C_ADDR_WIDTH-1:0] wr_addr;
  logic [C_DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]       wr_strb;
  logic [IDX_W-1:0]        wr_idx, rd_idx;
  logic [C_NUM_REGS-1:0]   wr_sel;
  logic [C_DATA_WIDTH-1:0] rd_data;
  logic                    rd_ok;

  // READYs decode straight from state so they are low while ARESET is held
  // and high in the very first cycle after it is released.
  assign S_AWREADY = !ARESET && (w_state == W_IDLE || w_state == W_HAVE_W);
  assign S_WREADY  = !ARESET && (w_state == W_IDLE || w_state == W_HAVE_AW);
  assign S_ARREADY = !ARESET && (r_state == R_IDLE);

  assign aw_hs   = S_AWVALID && S_AWREADY;
  assign w_hs    = S_WVALID  && S_WREADY;
  assign ar_hs   = S_ARVALID && S_ARREADY;
  assign have_aw = (w_state == W_HAVE_AW);
  assign have_w  = (w_state == W_HAVE_W);

  // Commit on the edge where the second half of the write arrives; the half
  // already latched comes from the holding register, the other from the bus.
  assign commit  = (aw_hs || have_aw) && (w_hs || have_w);
  assign wr_addr = have_aw ? aw_addr_q : S_AWADDR;
  assign wr_data = have_w  ? w_data_q  : S_WDATA;
  assign wr_strb = have_w  ? w_strb_q  : S_WSTRB;
  assign wr_idx  = wr_addr[C_ADDR_WIDTH-1:OFF_W];
  assign rd_idx  = S_ARADDR[C_ADDR_WIDTH-1:OFF_W];

  // Index decode by comparison against every slot: an index past the bank
  // simply matches nothing, which yields the SLVERR / zero-data answers.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_sel  = '0;
    rd_data = '0;
    rd_ok   = 1'b0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      wr_sel[i] = (wr_idx == IDX_W'(i)) && !C_RO_MASK[i];
      if (rd_idx == IDX_W'(i)) begin
        rd_ok   = 1'b1;
        rd_data = C_RO_MASK[i] ? status_in[i*C_DATA_WIDTH +: C_DATA_WIDTH] : regs[i];
      end
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      reg_out[i*C_DATA_WIDTH +: C_DATA_WIDTH] = C_RO_MASK[i] ? '0 : regs[i];
    end
  end

  // Write channel FSM.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state   <= W_IDLE;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      S_BVALID  <= 1'b0;
      S_BRESP   <= RESP_OKAY;
    end else if (commit) begin
      w_state  <= W_RESP;
      S_BVALID <= 1'b1;
      S_BRESP  <= (|wr_sel) ? RESP_OKAY : RESP_SLVERR;
    end else if (w_state == W_RESP) begin
      if (S_BREADY) begin
        w_state  <= W_IDLE;
        S_BVALID <= 1'b0;
      end
    end else if (aw_hs) begin
      aw_addr_q <= S_AWADDR;
      w_state   <= W_HAVE_AW;
    end else if (w_hs) begin
      w_data_q <= S_WDATA;
      w_strb_q <= S_WSTRB;
      w_state  <= W_HAVE_W;
    end
  end

  // Register bank and commit strobes.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      // NOTE: this storage is reset because its contents are software-visible right after reset.
      for (int i = 0; i < C_NUM_REGS; i++) regs[i] <= '0;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      for (int i = 0; i < C_NUM_REGS; i++) begin
        if (commit && wr_sel[i]) begin
          wr_pulse[i] <= 1'b1;
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) regs[i][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  // Read channel FSM.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state  <= R_IDLE;
      S_RVALID <= 1'b0;
      S_RDATA  <= '0;
      S_RRESP  <= RESP_OKAY;
    end else if (ar_hs) begin
      // NOTE: non-blocking updates mean a read sampled on a commit edge sees the pre-commit value.
      r_state  <= R_DATA;
      S_RVALID <= 1'b1;
      S_RDATA  <= rd_data;
      S_RRESP  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (r_state == R_DATA && S_RREADY) begin
      r_state  <= R_IDLE;
      S_RVALID <= 1'b0;
    end
  end

  // Protection bits and byte-offset address bits carry no function here;
  // status_in bits of writable slots are likewise never consulted.
  logic unused;
  assign unused = ^{S_AWPROT, S_ARPROT, S_AWADDR[OFF_W-1:0], S_ARADDR[OFF_W-1:0],
                    aw_addr_q[OFF_W-1:0], status_in};

endmodule

// File: tb/tb_axil_regfile_slave.sv
// Directed bench for axil_regfile_slave: 4 registers, register 3 read-only.
module tb_axil_regfile_slave;

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic [7:0]   S_AWADDR;
  logic [2:0]   S_AWPROT;
  logic         S_AWVALID, S_AWREADY;
  logic [31:0]  S_WDATA;
  logic [3:0]   S_WSTRB;
  logic         S_WVALID, S_WREADY;
  logic [1:0]   S_BRESP;
  logic         S_BVALID, S_BREADY;
  logic [7:0]   S_ARADDR;
  logic [2:0]   S_ARPROT;
  logic         S_ARVALID, S_ARREADY;
  logic [31:0]  S_RDATA;
  logic [1:0]   S_RRESP;
  logic         S_RVALID, S_RREADY;
  logic [127:0] reg_out;
  logic [127:0] status_in;
  logic [3:0]   wr_pulse;

  int tests = 0;
  int fails = 0;

  always #5 ACLK = ~ACLK;

  axil_regfile_slave #(
    .C_DATA_WIDTH(32),
    .C_NUM_REGS  (4),
    .C_ADDR_WIDTH(8),
    .C_RO_MASK   (4'b1000)
  ) dut (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .S_AWADDR (S_AWADDR),
    .S_AWPROT (S_AWPROT),
    .S_AWVALID(S_AWVALID),
    .S_AWREADY(S_AWREADY),
    .S_WDATA  (S_WDATA),
    .S_WSTRB  (S_WSTRB),
    .S_WVALID (S_WVALID),
    .S_WREADY (S_WREADY),
    .S_BRESP  (S_BRESP),
    .S_BVALID (S_BVALID),
    .S_BREADY (S_BREADY),
    .S_ARADDR (S_ARADDR),
    .S_ARPROT (S_ARPROT),
    .S_ARVALID(S_ARVALID),
    .S_ARREADY(S_ARREADY),
    .S_RDATA  (S_RDATA),
    .S_RRESP  (S_RRESP),
    .S_RVALID (S_RVALID),
    .S_RREADY (S_RREADY),
    .reg_out  (reg_out),
    .status_in(status_in),
    .wr_pulse (wr_pulse)
  );

  // Drive and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] slot(input int i);
    return reg_out[i*32 +: 32];
  endfunction

  task automatic write_both(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    S_AWADDR = a; S_AWVALID = 1'b1;
    S_WDATA = d; S_WSTRB = s; S_WVALID = 1'b1;
    tick();
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
  endtask

  task automatic b_ack();
    S_BREADY = 1'b1;
    tick();
    S_BREADY = 1'b0;
  endtask

  task automatic read_req(input logic [7:0] a);
    S_ARADDR = a; S_ARVALID = 1'b1;
    tick();
    S_ARVALID = 1'b0;
  endtask

  task automatic r_ack();
    S_RREADY = 1'b1;
    tick();
    S_RREADY = 1'b0;
  endtask

  logic [127:0] snap;

  initial begin
    ARESET = 1'b1;
    S_AWADDR = '0; S_AWPROT = '0; S_AWVALID = 1'b0;
    S_WDATA = '0; S_WSTRB = '0; S_WVALID = 1'b0; S_BREADY = 1'b0;
    S_ARADDR = '0; S_ARPROT = '0; S_ARVALID = 1'b0; S_RREADY = 1'b0;
    status_in = {32'hA5A5_A5A5, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};

    // Reset state.
    tick(); tick();
    check("rst_awready", S_AWREADY, 0);
    check("rst_wready", S_WREADY, 0);
    check("rst_arready", S_ARREADY, 0);
    check("rst_bvalid", S_BVALID, 0);
    check("rst_rvalid", S_RVALID, 0);
    check("rst_rdata", S_RDATA, 0);
    check("rst_wr_pulse", wr_pulse, 0);
    check("rst_reg_lo", reg_out[63:0], 0);
    check("rst_reg_hi", reg_out[127:64], 0);
    ARESET = 1'b0;
    #1;
    check("post_rst_awready", S_AWREADY, 1);
    check("post_rst_wready", S_WREADY, 1);
    check("post_rst_arready", S_ARREADY, 1);

    // Plain write then read of register 2.
    write_both(8'h08, 32'hDEAD_BEEF, 4'hF);
    check("w1_bvalid", S_BVALID, 1);
    check("w1_bresp", S_BRESP, 2'b00);
    check("w1_pulse", wr_pulse, 4'b0100);
    check("w1_reg2", slot(2), 32'hDEAD_BEEF);
    check("w1_awready_resp", S_AWREADY, 0);
    check("w1_wready_resp", S_WREADY, 0);
    b_ack();
    check("w1_bvalid_clr", S_BVALID, 0);
    check("w1_pulse_clr", wr_pulse, 0);
    check("w1_awready_idle", S_AWREADY, 1);
    read_req(8'h08);
    check("r1_rvalid", S_RVALID, 1);
    check("r1_rdata", S_RDATA, 32'hDEAD_BEEF);
    check("r1_rresp", S_RRESP, 2'b00);
    check("r1_arready", S_ARREADY, 0);
    r_ack();
    check("r1_rvalid_clr", S_RVALID, 0);
    check("r1_arready_idle", S_ARREADY, 1);

    // W three cycles ahead of AW, partial strobe over 0xFFFFFFFF.
    write_both(8'h04, 32'hFFFF_FFFF, 4'hF);
    b_ack();
    S_WDATA = 32'h1234_5678; S_WSTRB = 4'h3; S_WVALID = 1'b1;
    tick();
    S_WVALID = 1'b0;
    check("wfirst_wready", S_WREADY, 0);
    check("wfirst_awready", S_AWREADY, 1);
    check("wfirst_bvalid0", S_BVALID, 0);
    tick(); tick();
    check("wfirst_bvalid_wait", S_BVALID, 0);
    check("wfirst_reg1_wait", slot(1), 32'hFFFF_FFFF);
    S_AWADDR = 8'h04; S_AWVALID = 1'b1;
    tick();
    S_AWVALID = 1'b0;
    check("wfirst_bvalid", S_BVALID, 1);
    check("wfirst_bresp", S_BRESP, 2'b00);
    check("wfirst_pulse", wr_pulse, 4'b0010);
    check("wfirst_reg1", slot(1), 32'hFFFF_5678);
    b_ack();

    // Out-of-range index 4 (address 0x10).
    snap = reg_out;
    write_both(8'h10, 32'h5555_5555, 4'hF);
    check("oor_bresp", S_BRESP, 2'b10);
    check("oor_pulse", wr_pulse, 0);
    check("oor_regs_lo", reg_out[63:0], snap[63:0]);
    check("oor_regs_hi", reg_out[127:64], snap[127:64]);
    b_ack();
    read_req(8'h10);
    check("oor_rdata", S_RDATA, 0);
    check("oor_rresp", S_RRESP, 2'b10);
    r_ack();

    // Read-only register 3.
    write_both(8'h0C, 32'h7777_7777, 4'hF);
    check("ro_bresp", S_BRESP, 2'b10);
    check("ro_pulse", wr_pulse, 0);
    check("ro_slot_zero", slot(3), 0);
    b_ack();
    read_req(8'h0C);
    check("ro_rdata", S_RDATA, 32'hA5A5_A5A5);
    check("ro_rresp", S_RRESP, 2'b00);
    r_ack();

    // WSTRB=0 on writable register 0.
    write_both(8'h00, 32'h9999_9999, 4'h0);
    check("strb0_bresp", S_BRESP, 2'b00);
    check("strb0_pulse", wr_pulse, 4'b0001);
    check("strb0_reg0", slot(0), 0);
    b_ack();

    // Concurrent write and read with BREADY/RREADY held low for 5 cycles.
    S_ARADDR = 8'h08; S_ARVALID = 1'b1;
    write_both(8'h00, 32'hCAFE_F00D, 4'hF);
    S_ARVALID = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("hold_bvalid", S_BVALID, 1);
      check("hold_bresp", S_BRESP, 2'b00);
      check("hold_rvalid", S_RVALID, 1);
      check("hold_rdata", S_RDATA, 32'hDEAD_BEEF);
      check("hold_rresp", S_RRESP, 2'b00);
      check("hold_awready", S_AWREADY, 0);
      check("hold_arready", S_ARREADY, 0);
      tick();
    end
    check("hold_reg0", slot(0), 32'hCAFE_F00D);
    S_BREADY = 1'b1; S_RREADY = 1'b1;
    tick();
    S_BREADY = 1'b0; S_RREADY = 1'b0;
    check("hold_bvalid_clr", S_BVALID, 0);
    check("hold_rvalid_clr", S_RVALID, 0);

    // Read and commit to the same register on the same edge.
    S_ARADDR = 8'h08; S_ARVALID = 1'b1;
    write_both(8'h08, 32'h0BAD_F00D, 4'hF);
    S_ARVALID = 1'b0;
    check("same_edge_rdata", S_RDATA, 32'hDEAD_BEEF);
    check("same_edge_reg2", slot(2), 32'h0BAD_F00D);
    b_ack();
    r_ack();

    // AW ahead of W, byte offset bits ignored, single byte lane.
    S_AWADDR = 8'h03; S_AWVALID = 1'b1;
    tick();
    S_AWVALID = 1'b0;
    check("awfirst_awready", S_AWREADY, 0);
    check("awfirst_wready", S_WREADY, 1);
    check("awfirst_bvalid0", S_BVALID, 0);
    S_WDATA = 32'h00AB_0000; S_WSTRB = 4'b0100; S_WVALID = 1'b1;
    tick();
    S_WVALID = 1'b0;
    check("awfirst_bvalid", S_BVALID, 1);
    check("awfirst_reg0", slot(0), 32'hCAAB_F00D);
    check("awfirst_pulse", wr_pulse, 4'b0001);

    // Reset while BVALID and RVALID are up.
    read_req(8'h04);
    check("mid_rst_pre_bvalid", S_BVALID, 1);
    check("mid_rst_pre_rvalid", S_RVALID, 1);
    ARESET = 1'b1;
    tick();
    check("mid_rst_bvalid", S_BVALID, 0);
    check("mid_rst_rvalid", S_RVALID, 0);
    check("mid_rst_regs_lo", reg_out[63:0], 0);
    check("mid_rst_regs_hi", reg_out[127:64], 0);
    check("mid_rst_awready", S_AWREADY, 0);
    ARESET = 1'b0;

    // Reset with an AW latched: the pending write must be discarded.
    S_AWADDR = 8'h04; S_AWVALID = 1'b1;
    tick();
    S_AWVALID = 1'b0;
    check("pend_aw_latched", S_AWREADY, 0);
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    S_WDATA = 32'hFEED_FACE; S_WSTRB = 4'hF; S_WVALID = 1'b1;
    tick();
    S_WVALID = 1'b0;
    check("pend_no_bvalid", S_BVALID, 0);
    check("pend_no_pulse", wr_pulse, 0);
    check("pend_reg1", slot(1), 0);
    check("pend_wready", S_WREADY, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axil_regfile_slave.md
AXIL_REGFILE_SLAVE -- requirements
Module: axil_regfile_slave

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 32: AXI4-Lite data width, legal values 32 or 64.
REQ-002 SHALL have parameter C_NUM_REGS, default 16: number of registers, legal range 1..256.
REQ-003 SHALL have parameter C_ADDR_WIDTH, default 8: byte-address width, at least clog2(C_NUM_REGS)+clog2(C_DATA_WIDTH/8).
REQ-004 SHALL have parameter C_RO_MASK, default all-zero, C_NUM_REGS bits: bit i=1 makes register i read-only.
REQ-005 SHALL have these ports, with names given as the codebase does:
- ACLK  in  1  the single clock.
- ARESET  in  1  reset, synchronous and active-high.
REQ-006 S_AWADDR in C_ADDR_WIDTH; S_AWPROT in 3 (ignored); S_AWVALID in 1; S_AWREADY out 1.
REQ-007 S_WDATA in C_DATA_WIDTH; S_WSTRB in C_DATA_WIDTH/8; S_WVALID in 1; S_WREADY out 1.
REQ-008 S_BRESP out 2; S_BVALID out 1; S_BREADY in 1.
REQ-009 S_ARADDR in C_ADDR_WIDTH; S_ARPROT in 3 (ignored); S_ARVALID in 1; S_ARREADY out 1.
REQ-010 S_RDATA out C_DATA_WIDTH; S_RRESP out 2; S_RVALID out 1; S_RREADY in 1.
REQ-011 The remaining ports SHALL be:
- reg_out  out  C_NUM_REGS*C_DATA_WIDTH  current register contents.
- status_in  in  C_NUM_REGS*C_DATA_WIDTH  read-only sources.
- wr_pulse  out  C_NUM_REGS  one-cycle commit strobe per register.

Function
REQ-012 Register index SHALL be addr[C_ADDR_WIDTH-1:clog2(C_DATA_WIDTH/8)]; low byte-offset bits ignored.
REQ-013 Index >= C_NUM_REGS SHALL be out of range: write dropped with BRESP=SLVERR (2'b10); read returns RDATA=0, RRESP=SLVERR.
REQ-014 A write to a read-only index SHALL have no effect, SHALL raise no wr_pulse, and SHALL respond BRESP=SLVERR.
REQ-015 Write FSM SHALL have states W_IDLE, W_HAVE_AW, W_HAVE_W and W_RESP.
REQ-016 In W_IDLE, AWREADY and WREADY SHALL both be 1.
REQ-017 AW and W SHALL be accepted in either order or in the same cycle; each is latched independently.
REQ-018 The channel already latched SHALL drop its READY until the B handshake.
REQ-019 When both are latched, the commit SHALL occur on the next edge: BVALID=1, FSM enters W_RESP.
REQ-020 Commit to a writable register SHALL update only the byte lanes with WSTRB=1, and wr_pulse[i] SHALL be 1 for that single cycle.
REQ-021 WSTRB=0 on a writable register SHALL respond OKAY and SHALL still pulse wr_pulse[i].
REQ-022 In W_RESP, BVALID and BRESP SHALL hold stable until BREADY=1.
REQ-023 On the BREADY=1 edge the FSM SHALL return to W_IDLE; AWREADY and WREADY SHALL be 1 in the following cycle; there is no back-to-back bypass.
REQ-024 Read FSM SHALL have states R_IDLE (ARREADY=1) and R_DATA (ARREADY=0).
REQ-025 On the AR handshake edge, RDATA/RRESP SHALL be registered and RVALID=1 in the next cycle, giving one-cycle latency.
REQ-026 RDATA SHALL be the register contents, or the status_in slice sampled at the handshake edge for read-only indices.
REQ-027 RVALID/RDATA/RRESP SHALL hold stable until RREADY=1; the FSM then returns to R_IDLE.
REQ-028 Read and write channels SHALL operate concurrently.
REQ-029 An AR handshake on the same edge as a write commit to the same register SHALL return the pre-commit value.
REQ-030 reg_out SHALL reflect the commit from the cycle after the commit edge.
REQ-031 Read-only slots of reg_out SHALL drive 0.
REQ-032 The block SHALL allow at most one outstanding transaction per channel.

Reset
REQ-033 While ARESET=1 at an edge, all registers, BVALID, RVALID, BRESP, RRESP, RDATA and wr_pulse SHALL be 0; AWREADY, WREADY and ARREADY SHALL be 0.
REQ-034 Both FSMs SHALL enter their IDLE states, and the IDLE READYs SHALL be 1 on the first cycle after ARESET falls.
REQ-035 Reset asserted mid-transaction SHALL discard the latched AW/W/AR with no commit, and SHALL deassert BVALID/RVALID at that edge.

Verification
REQ-036 Scenario (default parameters): write 0xDEADBEEF to 0x08 with WSTRB=0xF, then read 0x08 -> BRESP=OKAY, wr_pulse[2] high for one cycle, RDATA=0xDEADBEEF, RRESP=OKAY.
REQ-037 Scenario: W presented 3 cycles before AW (addr 0x04, data 0x12345678, WSTRB=0x3) over old value 0xFFFFFFFF -> WREADY drops after W, BVALID one cycle after AW, reg 1 = 0xFFFF5678.
REQ-038 Scenario: C_NUM_REGS=4, write and read 0x10 -> BRESP=SLVERR, RRESP=SLVERR, RDATA=0, no wr_pulse, registers unchanged.
REQ-039 Scenario: C_RO_MASK bit 3 set, status_in slot 3=0xA5A5A5A5, write 0x0C then read 0x0C -> BRESP=SLVERR, RDATA=0xA5A5A5A5.
REQ-040 Scenario: hold BREADY and RREADY low for 5 cycles -> BVALID/RVALID, BRESP/RRESP and RDATA stay stable, and AWREADY/ARREADY stay 0 until the handshake.
REQ-041 Scenario: assert ARESET with BVALID=1 and a pending AW latched -> next cycle BVALID=0, registers 0, and no commit of the pending write.
